bin_to_bcd: RTL and testbench

Registered 6-bit binary to two-digit BCD converter for the digital watch datapath. It takes a seconds, minutes or hours count (0–63) and produces tens and units BCD digits for the seven-segment decoders. Conversion is purely combinational, using shift-add-3 (double-dabble), with one output register stage. The module is instantiated as `bin2bcd`.

---
 rtl/bin_to_bcd.sv | 29 ++
 tb/tb_bin_to_bcd.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: registered 6-bit binary to two-digit BCD converter using double-dabble
module bin_to_bcd (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] binary,
  output logic [3:0] high_bcd,
  output logic [3:0] low_bcd
);
  logic [7:0] bcd;
  logic [3:0] high_d, high_q, low_d, low_q;
  // shift-add-3 over all six input bits, MSB first
  always_comb begin
    bcd = 8'd0;
    for (int i = 5; i >= 0; i--) begin
      bcd[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
      bcd[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
      bcd = {bcd[6:0], binary[i]};
    end
    high_d = bcd[7:4];
    low_d = bcd[3:0];
  end
  // output register; reset wins over the new conversion
  always_ff @(posedge clock) begin
    high_q <= reset ? 4'd0 : high_d;
    low_q <= reset ? 4'd0 : low_d;
  end
  assign high_bcd = high_q;
  assign low_bcd = low_q;
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: randomized and directed checks of bin_to_bcd against a div/mod model
module tb_bin_to_bcd;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [5:0] binary = 6'd0;
  logic [3:0] high_bcd, low_bcd;
  int checks = 0;
  int errors = 0;

  bin_to_bcd bin2bcd (
    .clock(clock),
    .reset(reset),
    .binary(binary),
    .high_bcd(high_bcd),
    .low_bcd(low_bcd)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input int th, input int tl);
    checks++;
    if (high_bcd !== 4'(th) || low_bcd !== 4'(tl)) begin
      errors++;
      $display("FAIL %s: got %0d,%0d expected %0d,%0d", name, high_bcd, low_bcd, th, tl);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    binary = 6'd45;
    tick();
    expect_out("reset_edge1", 0, 0);
    tick();
    expect_out("reset_edge2", 0, 0);
    reset = 1'b0;
    tick();
    expect_out("reset_release", 4, 5);
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 64; v++) begin
      binary = 6'(v);
      tick();
      expect_out($sformatf("sweep_%0d", v), v / 10, v % 10);
      checks++;
      if (high_bcd > 4'd6 || low_bcd > 4'd9) begin
        errors++;
        $display("FAIL sweep_range_%0d: got %0d,%0d expected tens<=6 units<=9", v, high_bcd, low_bcd);
      end
    end
  endtask

  task automatic test_latency();
    binary = 6'd19;
    tick();
    expect_out("latency_19", 1, 9);
    binary = 6'd20;
    #2;
    expect_out("latency_hold_before_edge", 1, 9);
    tick();
    expect_out("latency_20", 2, 0);
  endtask

  task automatic test_reset_midstream();
    for (int v = 30; v < 42; v++) begin
      binary = 6'(v);
      reset = (v == 37);
      tick();
      if (v == 37) expect_out("midstream_reset", 0, 0);
      else expect_out($sformatf("midstream_%0d", v), v / 10, v % 10);
    end
    reset = 1'b0;
  endtask

  task automatic test_hold();
    binary = 6'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("hold_0", 0, 0);
    end
    binary = 6'd50;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("hold_50", 5, 0);
    end
  endtask

  task automatic test_random();
    int v;
    bit r;
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 63);
      r = ($urandom_range(0, 15) == 0);
      binary = 6'(v);
      reset = r;
      tick();
      if (r) expect_out("random_reset", 0, 0);
      else expect_out($sformatf("random_%0d", v), v / 10, v % 10);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int q[$];
    for (int i = 0; i < 20; i++) q.push_back($urandom_range(0, 63));
    foreach (q[i]) begin
      binary = 6'(q[i]);
      tick();
      binary = 6'($urandom_range(0, 63));
      #2;
      expect_out($sformatf("b2b_hold_%0d", q[i]), q[i] / 10, q[i] % 10);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_latency();
    test_reset_midstream();
    test_hold();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
